// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and state encoding for the CNN window feeder
package cnn_pkg;

    localparam int IMG_W   = 28;
    localparam int K       = 5;
    localparam int PIX_W   = 8;
    localparam int N_OUT   = IMG_W - K + 1;
    localparam int WIN_W   = K * K * PIX_W;
    localparam int N_PIX   = IMG_W * IMG_W;
    localparam int ADDR_W  = $clog2(N_PIX);
    localparam int COORD_W = $clog2(N_OUT);

    localparam logic [3:0] TIMEOUT_CLASS = 4'hF;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_STREAM,
        ST_WAIT,
        ST_RESULT
    } state_t;

endpackage

// File: rtl/cnn_frame_buf.sv
// rtl/cnn_frame_buf.sv - 28x28 pixel store with single write port and 5x5 window read
module cnn_frame_buf
    import cnn_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIX_W-1:0]   wr_data,
    input  logic [COORD_W-1:0] win_x,
    input  logic [COORD_W-1:0] win_y,
    output logic [WIN_W-1:0]   window
);

    logic [PIX_W-1:0] mem [N_PIX];

    // Image contents are overwritten every frame, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Top-left pixel lands in the most significant byte; rows fill downward.
    always_comb begin
        window = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                window[WIN_W-1-(r*K+c)*PIX_W -: PIX_W] =
                    mem[ADDR_W'((int'(win_y) + r) * IMG_W + int'(win_x) + c)];
            end
        end
    end

endmodule

// File: rtl/cnn_window_feeder.sv
// rtl/cnn_window_feeder.sv - buffers one image and streams 576 5x5 windows into simpleCNN
module cnn_window_feeder
    import cnn_pkg::*;
#(
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               PIX_VALID,
    input  logic [PIX_W-1:0]   PIX_DATA,
    output logic               PIX_READY,
    output logic               START,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic [WIN_W-1:0]   IMGIN,
    input  logic               DONE,
    input  logic [3:0]         OUT,
    output logic               RES_VALID,
    output logic [3:0]         RES_CLASS,
    output logic               RES_TIMEOUT,
    output logic               BUSY
);

    localparam int TO_W = $clog2(DONE_TIMEOUT + 1);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   pix_cnt_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic [COORD_W-1:0]  rd_x;
    logic [COORD_W-1:0]  rd_y;
    logic [WIN_W-1:0]    rd_window;
    logic                accept;
    logic                last_pix;
    logic                last_win;
    logic                to_hit;
    logic                load_win;

    assign accept   = PIX_VALID && PIX_READY && (state_q == ST_LOAD);
    assign last_pix = accept && (pix_cnt_q == ADDR_W'(N_PIX - 1));
    assign last_win = (X == COORD_W'(N_OUT - 1)) && (Y == COORD_W'(N_OUT - 1));
    assign to_hit   = (to_cnt_q == TO_W'(DONE_TIMEOUT - 1));

    cnn_frame_buf u_frame_buf (
        .clk     (CLK),
        .we      (accept),
        .wr_addr (pix_cnt_q),
        .wr_data (PIX_DATA),
        .win_x   (rd_x),
        .win_y   (rd_y),
        .window  (rd_window)
    );

    // rd_x/rd_y name the window that becomes visible after the coming edge.
    always_comb begin
        state_d  = state_q;
        rd_x     = X;
        rd_y     = Y;
        load_win = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (last_pix) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d  = ST_STREAM;
                rd_x     = '0;
                rd_y     = '0;
                load_win = 1'b1;
            end
            ST_STREAM: begin
                if (last_win) begin
                    state_d = ST_WAIT;
                end else begin
                    load_win = 1'b1;
                    if (Y == COORD_W'(N_OUT - 1)) begin
                        rd_x = X + 1'b1;
                        rd_y = '0;
                    end else begin
                        rd_y = Y + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (DONE || to_hit) begin
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_LOAD;
            pix_cnt_q   <= '0;
            to_cnt_q    <= '0;
            PIX_READY   <= 1'b0;
            START       <= 1'b0;
            BUSY        <= 1'b0;
            RES_VALID   <= 1'b0;
            RES_CLASS   <= '0;
            RES_TIMEOUT <= 1'b0;
            X           <= '0;
            Y           <= '0;
            IMGIN       <= '0;
        end else begin
            state_q   <= state_d;
            PIX_READY <= (state_d == ST_LOAD);
            START     <= (state_d == ST_START);
            BUSY      <= (state_d == ST_START) || (state_d == ST_STREAM) || (state_d == ST_WAIT);
            RES_VALID <= (state_d == ST_RESULT);

            if (accept) begin
                pix_cnt_q <= last_pix ? '0 : pix_cnt_q + 1'b1;
            end

            if (load_win) begin
                X     <= rd_x;
                Y     <= rd_y;
                IMGIN <= rd_window;
            end

            to_cnt_q <= (state_q == ST_WAIT) ? to_cnt_q + 1'b1 : '0;

            // DONE takes priority when it coincides with the timeout edge.
            if (state_q == ST_WAIT && state_d == ST_RESULT) begin
                RES_CLASS   <= DONE ? OUT : TIMEOUT_CLASS;
                RES_TIMEOUT <= !DONE;
            end
        end
    end

endmodule
